// File: rtl/mem_stage_controller_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer: opcode
// constants, opcode field position, FSM state encoding and counter widths.
package mem_stage_controller_pkg;

    localparam int unsigned INSN_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OPC_W       = 5;
    localparam int unsigned OPC_MSB     = 31;
    localparam int unsigned OPC_LSB     = 27;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned STALL_CNT_W = 16;

    localparam logic [OPC_W-1:0] OP_LW = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SW = 5'b00111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        DONE      = 2'd2
    } mem_state_e;

    // Opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSN_W-1:0] insn);
        return insn[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/mem_stage_controller_latency_counter.sv
// mem_latency_counter: loadable down-counter that times the dmem read latency.
// Ports:
//   i_clock      rising-edge clock
//   i_reset_n    asynchronous active-low reset (count cleared to 0)
//   i_load       load i_load_val (has priority over decrement)
//   i_load_val   value to load
//   i_dec        decrement by one; holds at zero
//   o_is_one_c   combinational flag, count == 1
module mem_latency_counter
    import mem_stage_controller_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one_c
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: load wins over decrement, decrement floors at zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_is_one_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: sequences the MEM-stage data-memory access. Stores
// issue in one cycle; loads stall the upstream pipeline and bubble MEM/WB
// until the fixed-latency read data is captured. Counts load-stall cycles.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   insn_in              EX/MEM instruction, opcode in [31:27]
//   addr_in              effective address, low ADDR_W bits used
//   store_data_in        store data
//   dmem_addr/rden/wren/data  data-memory request
//   dmem_q               read data, valid LATENCY cycles after issue
//   load_data            captured load result for MEM/WB
//   stall                freezes PC and upstream latches
//   mw_nop               forces the MEM/WB instruction to a nop
//   stall_cycles         saturating count of stall cycles
// LATENCY must be in 1..7 (3-bit latency counter).
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            insn_in,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            store_data_in,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic                   dmem_rden,
    output logic                   dmem_wren,
    output logic [31:0]            dmem_data,
    input  logic [31:0]            dmem_q,
    output logic [31:0]            load_data,
    output logic                   stall,
    output logic                   mw_nop,
    output logic [15:0]            stall_cycles
);

    mem_state_e               r_state;
    mem_state_e               w_next_state;
    logic [ADDR_W-1:0]        r_addr_q;
    logic [DATA_W-1:0]        r_load_data;
    logic [STALL_CNT_W-1:0]   r_stall_cycles;

    logic [OPC_W-1:0]         w_opcode;
    logic                     w_is_lw;
    logic                     w_is_sw;
    logic                     w_cnt_load;
    logic                     w_cnt_dec;
    logic                     w_cnt_is_one;
    logic                     w_capture;
    logic                     w_latch_addr;
    logic                     w_unused_bits;

    assign w_opcode = opcode_of(insn_in);
    assign w_is_lw  = (w_opcode == OP_LW);
    assign w_is_sw  = (w_opcode == OP_SW);

    // Only the opcode and the low address bits matter here.
    assign w_unused_bits = &{1'b0, insn_in[OPC_LSB-1:0], addr_in[31:ADDR_W]};

    // Read-latency timer, loaded on lw issue and stepped in READ_WAIT.
    mem_latency_counter u_lat_cnt (
        .i_clock    (clock),
        .i_reset_n  (reset),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(LATENCY)),
        .i_dec      (w_cnt_dec),
        .o_is_one_c (w_cnt_is_one)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and memory/pipeline control; Mealy on insn_in only in IDLE.
    always_comb begin
        w_next_state = r_state;
        dmem_rden    = 1'b0;
        dmem_wren    = 1'b0;
        dmem_addr    = addr_in[ADDR_W-1:0];
        dmem_data    = store_data_in;
        stall        = 1'b0;
        mw_nop       = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_capture    = 1'b0;
        w_latch_addr = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_is_lw) begin
                    dmem_rden    = 1'b1;
                    stall        = 1'b1;
                    mw_nop       = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_latch_addr = 1'b1;
                    w_next_state = READ_WAIT;
                end else if (w_is_sw) begin
                    dmem_wren    = 1'b1;
                end
            end
            READ_WAIT: begin
                dmem_rden = 1'b1;
                dmem_addr = r_addr_q;
                stall     = 1'b1;
                mw_nop    = 1'b1;
                w_cnt_dec = 1'b1;
                if (w_cnt_is_one) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // The stalled lw is still in the latch; it must not re-issue.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Reset drops every request and the stall without waiting for a clock.
        if (!reset) begin
            dmem_rden = 1'b0;
            dmem_wren = 1'b0;
            dmem_addr = '0;
            dmem_data = '0;
            stall     = 1'b0;
            mw_nop    = 1'b0;
        end
    end

    // Load address latch and load data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_q    <= '0;
            r_load_data <= '0;
        end else begin
            if (w_latch_addr) begin
                r_addr_q <= addr_in[ADDR_W-1:0];
            end
            if (w_capture) begin
                r_load_data <= dmem_q;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign load_data    = r_load_data;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Sequencer for the data-memory access performed in the MEM stage of the five-stage pipeline. It decodes the instruction held in the EX/MEM latch and issues reads and writes to the fixed-latency data memory. During a load it stalls the upstream pipeline and inserts a nop into the MEM/WB latch until the read data is captured. It also keeps a saturating count of load-stall cycles for performance measurement.

## Interface

Parameters:
- LATENCY, 2: dmem read latency in cycles; legal range 1..7.
- ADDR_W, 12: dmem word-address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- insn_in  in  32  instruction in the EX/MEM latch; opcode is [31:27]
- addr_in  in  32  ALU result (effective address); only [ADDR_W-1:0] are used
- store_data_in  in  32  store data from the EX/MEM latch
- dmem_addr  out  ADDR_W  data-memory address
- dmem_rden  out  1  read enable
- dmem_wren  out  1  write enable
- dmem_data  out  32  write data
- dmem_q  in  32  read data; valid LATENCY cycles after the issue cycle
- load_data  out  32  captured load result, feeding the MEM/WB dmem input
- stall  out  1  freezes the PC and the F/D, D/X and X/M latches
- mw_nop  out  1  forces the MEM/WB instruction input to 32'h0
- stall_cycles  out  16  saturating count of cycles with stall=1

## Operation

Opcodes: lw = 5'b01000, sw = 5'b00111. All other opcodes are non-memory.

The FSM has three states.
- IDLE
  - Non-memory instruction: all enables 0, stall=0, mw_nop=0.
  - sw: dmem_wren=1, dmem_addr=addr_in[ADDR_W-1:0], dmem_data=store_data_in, stall=0. Stays in IDLE; the write completes in one cycle.
  - lw: dmem_rden=1, dmem_addr=addr_in[ADDR_W-1:0], stall=1, mw_nop=1. The address is latched into addr_q and cnt<=LATENCY. Next state is READ_WAIT.
- READ_WAIT
  - dmem_rden=1, dmem_addr=addr_q, stall=1, mw_nop=1.
  - cnt decrements each cycle.
  - When cnt==1: load_data<=dmem_q, next state is DONE.
- DONE
  - stall=0, mw_nop=0, all enables 0.
  - The pipeline advances and MEM/WB captures the lw with load_data.
  - Next state is IDLE unconditionally. insn_in is ignored in this cycle so the same lw cannot be re-issued.

Datapath rules:
- load_data holds its value except on a capture.
- stall_cycles increments on every cycle with stall=1 and saturates at 16'hFFFF.
- When no write is issued, dmem_data=store_data_in, which is don't-care to the memory.

## Timing

- Reset (reset=0, asynchronous): state=IDLE, cnt=0, addr_q=0, load_data=0, stall_cycles=0. Outputs while held in reset: dmem_rden=0, dmem_wren=0, dmem_addr=0, dmem_data=0, stall=0, mw_nop=0.
- lw issued in cycle t0:
  - stall=1 during cycles t0..t0+LATENCY, i.e. LATENCY+1 cycles.
  - Data is captured at the end of cycle t0+LATENCY.
  - DONE occurs in cycle t0+LATENCY+1.
  - For LATENCY=1: two stall cycles.
- A sw completes in zero stall cycles. Back-to-back sw instructions issue one per cycle.
- lw immediately following a lw: the second lw is seen in the IDLE cycle after DONE, so there is no gap beyond DONE.
- sw arriving in the DONE cycle cannot occur, because the stalled lw is still in the latch.
- Reset asserted mid-READ_WAIT: the read is abandoned and stall drops immediately, asynchronously. load_data is cleared.
- stall and mw_nop are Moore-like in READ_WAIT and Mealy on insn_in in IDLE. Upstream latches must use stall as a synchronous enable.

## Structure

- The shared package or header holds OP_LW, OP_SW, the opcode field slice [31:27], and the state encodings IDLE=2'd0, READ_WAIT=2'd1, DONE=2'd2.
- Sub-module mem_latency_counter: a 3-bit loadable down-counter with a load/decrement interface and an is_one flag, using the same asynchronous active-low reset.
- The remaining logic (FSM, address/data latches, stall counter) lives in one module. The implementation is 150–250 lines.

## Test plan

- Reset: hold reset=0 with insn_in=lw → all outputs 0. Release reset with a non-memory insn → stall stays 0.
- lw, LATENCY=2, addr_in=32'h0000_0010, dmem_q=32'hDEAD_BEEF at cycle t0+2:
  - dmem_rden=1 and dmem_addr=12'h010 for cycles t0..t0+2.
  - stall=1 for 3 cycles.
  - load_data=32'hDEAD_BEEF in cycle t0+3, with stall=0.
- sw addr_in=5, store_data_in=32'h1234 → in the same cycle dmem_wren=1, dmem_addr=5, dmem_data=32'h1234, stall=0. The next cycle has dmem_wren=0.
- lw, lw, sw back-to-back with LATENCY=1:
  - Each lw stalls for exactly 2 cycles.
  - The sw issues in the IDLE cycle after the second lw's DONE.
  - stall_cycles=4.
- Reset asserted in the first READ_WAIT cycle: stall drops to 0 without waiting for a clock edge, and load_data=0. After reset is released with insn_in still lw, a fresh lw issue occurs.
- Saturation: force 70000 stall cycles → stall_cycles=16'hFFFF and holds.
